// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: drives the BNN core's user-clock port (chain load and nibble-wise inference) from the system clock
// Ports: clk/rst_n system clock and sync active-low reset; cfg_* parameter byte stream (LSB first);
//        infer_* inference request; res_valid/res_y captured result; params_loaded/busy status;
//        bnn_clk/bnn_setup/bnn_param/bnn_x_bank_hi/bnn_x drive the core; bnn_y core outputs.
module bnn_seq_ctrl #(
  parameter int CHAIN_BITS    = 144,
  parameter int HALF_PERIOD   = 2,
  parameter int EVAL_TICKS    = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       infer_valid,
  output logic       infer_ready,
  input  logic [7:0] infer_x,
  output logic       res_valid,
  output logic [7:0] res_y,
  output logic       params_loaded,
  output logic       busy,
  output logic       bnn_clk,
  output logic       bnn_setup,
  output logic       bnn_param,
  output logic       bnn_x_bank_hi,
  output logic [3:0] bnn_x,
  input  logic [7:0] bnn_y
);
  localparam int CMAX = (2 * HALF_PERIOD > SETTLE_CYCLES) ? 2 * HALF_PERIOD : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = (CHAIN_BITS > 8) ? $clog2(CHAIN_BITS) : 3;
  localparam int EW = (EVAL_TICKS > 1) ? $clog2(EVAL_TICKS) : 1;
  localparam logic [CW-1:0] T_RISE = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] T_END  = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(CHAIN_BITS - 1);
  localparam logic [EW-1:0] E_LAST = EW'(EVAL_TICKS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BYTE, INFER_LO, INFER_HI, EVAL, SETTLE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bit_idx, bit_d;
  logic [EW-1:0] ev, ev_d;
  logic [7:0] sh, sh_d, x_q, x_d, res_y_d;
  logic [3:0] xo_d;
  logic infer_rdy, infer_rdy_d, cfg_ready_d, res_valid_d, loaded_d, busy_d;
  logic clk_d, setup_d, param_d, bank_d;
  logic cfg_acc, inf_acc, tick, tick_end, ticks_done;
  // cfg has priority: a simultaneous cfg offer withdraws infer_ready in the same cycle
  assign infer_ready = infer_rdy & ~cfg_valid;
  assign cfg_acc = cfg_valid & cfg_ready;
  assign inf_acc = infer_valid & infer_ready;
  assign tick = state inside {LOAD, INFER_LO, INFER_HI, EVAL};
  assign tick_end = tick && cnt == T_END;
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    bit_d = bit_idx;
    ev_d = ev;
    sh_d = sh;
    x_d = x_q;
    clk_d = (tick && cnt == T_RISE) ? 1'b1 : bnn_clk;
    setup_d = bnn_setup;
    param_d = bnn_param;
    bank_d = bnn_x_bank_hi;
    xo_d = bnn_x;
    res_valid_d = 1'b0;
    res_y_d = res_y;
    loaded_d = params_loaded;
    ticks_done = 1'b0;
    if (tick_end) begin
      clk_d = 1'b0;
      cnt_d = '0;
    end
    case (state)
      IDLE:
        if (cfg_acc) begin
          state_d = LOAD;
          cnt_d = '0;
          bit_d = '0;
          sh_d = cfg_data;
          setup_d = 1'b1;
          param_d = cfg_data[0];
          loaded_d = 1'b0;
        end else if (inf_acc) begin
          state_d = INFER_LO;
          cnt_d = '0;
          x_d = infer_x;
          bank_d = 1'b0;
          xo_d = infer_x[3:0];
        end
      LOAD:
        if (tick_end) begin
          if (bit_idx == B_LAST) begin
            state_d = IDLE;
            setup_d = 1'b0;
            param_d = 1'b0;
            loaded_d = 1'b1;
          end else if (bit_idx[2:0] != 3'd7) begin
            bit_d = bit_idx + 1'b1;
            sh_d = sh >> 1;
            param_d = sh[1];
          end else if (cfg_acc) begin
            bit_d = bit_idx + 1'b1;
            sh_d = cfg_data;
            param_d = cfg_data[0];
          end else begin
            state_d = WAIT_BYTE;
          end
        end
      WAIT_BYTE: begin
        cnt_d = '0;
        if (cfg_acc) begin
          state_d = LOAD;
          bit_d = bit_idx + 1'b1;
          sh_d = cfg_data;
          param_d = cfg_data[0];
        end
      end
      INFER_LO:
        if (tick_end) begin
          state_d = INFER_HI;
          bank_d = 1'b1;
          xo_d = x_q[7:4];
        end
      INFER_HI:
        if (tick_end) begin
          state_d = EVAL;
          ev_d = '0;
          ticks_done = EVAL_TICKS == 0;
        end
      EVAL:
        if (tick_end) begin
          ev_d = ev + 1'b1;
          ticks_done = ev == E_LAST;
        end
      SETTLE:
        if (cnt == S_LAST) begin
          state_d = IDLE;
          res_valid_d = 1'b1;
          res_y_d = bnn_y;
        end
      default: state_d = IDLE;
    endcase
    if (ticks_done) begin
      state_d = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
      res_valid_d = SETTLE_CYCLES == 0;
      res_y_d = (SETTLE_CYCLES == 0) ? bnn_y : res_y;
    end
    busy_d = state_d != IDLE;
    // ready is also raised in the last cycle of a byte's 8th tick so an unstalled next byte costs no cycle
    cfg_ready_d = state_d == IDLE || state_d == WAIT_BYTE ||
                  (state_d == LOAD && cnt_d == T_END && bit_d[2:0] == 3'd7 && bit_d != B_LAST);
    infer_rdy_d = state_d == IDLE && loaded_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      ev <= '0;
      sh <= '0;
      x_q <= '0;
      bnn_clk <= 1'b0;
      bnn_setup <= 1'b0;
      bnn_param <= 1'b0;
      bnn_x_bank_hi <= 1'b0;
      bnn_x <= '0;
      res_valid <= 1'b0;
      res_y <= '0;
      params_loaded <= 1'b0;
      busy <= 1'b0;
      cfg_ready <= 1'b1;
      infer_rdy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_idx <= bit_d;
      ev <= ev_d;
      sh <= sh_d;
      x_q <= x_d;
      bnn_clk <= clk_d;
      bnn_setup <= setup_d;
      bnn_param <= param_d;
      bnn_x_bank_hi <= bank_d;
      bnn_x <= xo_d;
      res_valid <= res_valid_d;
      res_y <= res_y_d;
      params_loaded <= loaded_d;
      busy <= busy_d;
      cfg_ready <= cfg_ready_d;
      infer_rdy <= infer_rdy_d;
    end
  end
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: directed and randomized checks of bnn_seq_ctrl against a transaction-level model
module tb_bnn_seq_ctrl;
  localparam int CB = 12;
  localparam int H = 2;
  localparam int E = 1;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, infer_valid = 1'b0;
  logic [7:0] cfg_data = '0, infer_x = '0, bnn_y = '0;
  logic cfg_ready, infer_ready, res_valid, params_loaded, busy;
  logic bnn_clk, bnn_setup, bnn_param, bnn_x_bank_hi;
  logic [7:0] res_y;
  logic [3:0] bnn_x;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, ld_cyc = -1, res_cyc = -1, res_n = 0;
  logic pclk = 1'b0, pld = 1'b0;
  logic [6:0] q[$];

  bnn_seq_ctrl #(.CHAIN_BITS(CB), .HALF_PERIOD(H), .EVAL_TICKS(E), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .infer_valid(infer_valid), .infer_ready(infer_ready), .infer_x(infer_x),
    .res_valid(res_valid), .res_y(res_y), .params_loaded(params_loaded), .busy(busy),
    .bnn_clk(bnn_clk), .bnn_setup(bnn_setup), .bnn_param(bnn_param),
    .bnn_x_bank_hi(bnn_x_bank_hi), .bnn_x(bnn_x), .bnn_y(bnn_y)
  );

  always #5 clk = ~clk;

  // records every bnn_clk rise with the data the core would sample, plus event cycles
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bnn_clk === 1'b1 && pclk === 1'b0) q.push_back({bnn_setup, bnn_param, bnn_x_bank_hi, bnn_x});
    if (params_loaded === 1'b1 && pld === 1'b0) ld_cyc = cyc;
    if (res_valid === 1'b1) begin
      res_cyc = cyc;
      res_n++;
    end
    pclk = bnn_clk;
    pld = params_loaded;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {bnn_clk, bnn_setup, bnn_param, bnn_x_bank_hi, bnn_x, res_valid, res_y,
              params_loaded, busy, cfg_ready, infer_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic send_cfg(input logic [7:0] b, output int k);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data = b;
    while (cfg_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_accept", cfg_ready, 1);
    k = cyc + 1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data = 8'($urandom);
  endtask

  // the second byte is offered d cycles after the earliest cycle it could be taken
  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int d);
    int k, k2, n;
    logic [15:0] chain;
    chain = {b1, b0};
    q.delete();
    ld_cyc = -1;
    send_cfg(b0, k);
    chk("load_setup_start", bnn_setup, 1);
    chk("load_busy", busy, 1);
    while (cyc < k + 8 * 2 * H - 1 + d) begin
      @(negedge clk);
      if (cyc >= k + 8 * 2 * H && cyc < k + 8 * 2 * H + d) begin
        chk("stall_clk_low", bnn_clk, 0);
        chk("stall_setup_high", bnn_setup, 1);
      end
    end
    send_cfg(b1, k2);
    chk("byte2_accept_cycle", k2, k + 8 * 2 * H + d);
    n = 0;
    while (params_loaded !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("loaded_cycle", ld_cyc, k + CB * 2 * H + d);
    chk("rise_count", q.size(), CB);
    for (int i = 0; i < CB && i < q.size(); i++) begin
      chk("load_rise_setup", q[i][6], 1);
      chk("load_rise_param", q[i][5], chain[i]);
    end
    chk("post_load_pins", {bnn_setup, bnn_param, busy, cfg_ready, infer_ready}, 5'b00011);
  endtask

  task automatic do_infer(input logic [7:0] x, input logic [7:0] y);
    int k, n, r0;
    logic [3:0] nib;
    r0 = res_n;
    q.delete();
    bnn_y = y;
    infer_valid = 1'b1;
    infer_x = x;
    n = 0;
    while (infer_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("infer_accept", infer_ready, 1);
    k = cyc + 1;
    @(negedge clk);
    infer_valid = 1'b0;
    infer_x = 8'($urandom);
    chk("infer_busy", busy, 1);
    n = 0;
    while (res_n == r0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_cycle", res_cyc, k + (2 + E) * 2 * H + S);
    chk("res_y", res_y, y);
    chk("idle_first_cycle_ready", {busy, infer_ready, cfg_ready}, 3'b011);
    chk("infer_rise_count", q.size(), 2 + E);
    for (int i = 0; i < q.size() && i < 2 + E; i++) begin
      nib = (i == 0) ? x[3:0] : x[7:4];
      chk("infer_rise", q[i], {1'b0, 1'b0, i != 0, nib});
    end
    bnn_y = ~y;
    @(negedge clk);
    chk("res_pulse_one_cycle", res_valid, 0);
    chk("res_y_held", res_y, y);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    rst_n = 1'b1;
    q.delete();
    repeat (20) @(negedge clk);
    chk("idle_no_bnn_clk", q.size(), 0);
    chk_reset("idle_values");
    infer_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("infer_gated_unloaded", {infer_ready, busy}, 2'b00);
    end
    infer_valid = 1'b0;
    do_load(8'hB4, 8'h0F, 0);
    do_load(8'($urandom), 8'($urandom), 10);
    do_infer(8'hA5, 8'h3C);
    do_infer(8'($urandom), 8'($urandom));
    for (int it = 0; it < 3; it++) begin
      do_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 6)));
      do_infer(8'($urandom), 8'($urandom));
      do_infer(8'($urandom), 8'($urandom));
    end
    cfg_valid = 1'b1;
    cfg_data = 8'($urandom);
    infer_valid = 1'b1;
    #1;
    chk("prio_ready", {cfg_ready, infer_ready}, 2'b10);
    q.delete();
    @(negedge clk);
    cfg_valid = 1'b0;
    infer_valid = 1'b0;
    chk("prio_cfg_won", {params_loaded, busy, bnn_setup}, 3'b011);
    n = 0;
    while (q.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_tick_reached", q.size(), 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midload_reset");
    rst_n = 1'b1;
    infer_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_infer_gated", {infer_ready, busy, params_loaded}, 3'b000);
    end
    infer_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
